// File: rtl/nnrv_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package nnrv_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    // Width of the starvation counter; holds STARVE_MAX-1 for STARVE_MAX up to 15.
    localparam int unsigned WB_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FORCE = 2'd2
    } wb_arb_state_t;

endpackage

// File: rtl/nnrv_wb_buf.sv
// One-entry holding register for a pending MDU register write.
module nnrv_wb_buf
    import nnrv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [XLEN-1:0]       i_data,
    output logic                  o_valid,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [XLEN-1:0]       o_data
);

    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;

    // Load captures a new entry; clear empties it.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (i_load) begin
            valid_d = 1'b1;
            rd_d    = i_rd;
            data_d  = i_data;
        end else if (i_clear) begin
            valid_d = 1'b0;
            rd_d    = REG_X0;
            data_d  = '0;
        end
    end

    // Entry storage with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            rd_q    <= REG_X0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_rd    = rd_q;
    assign o_data  = data_q;

endmodule

// File: rtl/nnrv_wb_arb.sv
// Register-file write-port arbiter: pipeline writeback has priority with zero
// latency; a buffered MDU result drains into the first free slot, and a
// starvation counter freezes the pipeline so the MDU result always lands.
module nnrv_wb_arb
    import nnrv_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wb_en,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]       i_wb_data,
    input  logic                  i_mdu_valid,
    input  logic [REG_ADDR_W-1:0] i_mdu_rd,
    input  logic [XLEN-1:0]       i_mdu_data,
    output logic                  o_mdu_ready,
    output logic                  o_pipe_stall,
    output logic                  o_buf_busy,
    output logic [REG_ADDR_W-1:0] o_buf_rd,
    output logic                  o_err,
    output logic                  o_reg_w_en,
    output logic [REG_ADDR_W-1:0] o_reg_w,
    output logic [XLEN-1:0]       o_reg_w_reg
);

    localparam logic [WB_CNT_W-1:0] CNT_LIMIT = WB_CNT_W'(STARVE_MAX - 1);
    localparam logic [WB_CNT_W-1:0] CNT_SAT   = {WB_CNT_W{1'b1}};

    wb_arb_state_t          state_q, state_d;
    logic [WB_CNT_W-1:0]    cnt_q, cnt_d;
    logic                   stall_q, stall_d;
    logic                   err_q, err_d;

    logic                   buf_load, buf_clear;
    logic                   buf_valid;
    logic [REG_ADDR_W-1:0]  buf_rd;
    logic [XLEN-1:0]        buf_data;

    logic                   pipe_wr;
    logic                   busy;
    logic                   collide;
    logic                   drain;

    nnrv_wb_buf #(
        .XLEN (XLEN)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (buf_load),
        .i_clear (buf_clear),
        .i_rd    (i_mdu_rd),
        .i_data  (i_mdu_data),
        .o_valid (buf_valid),
        .o_rd    (buf_rd),
        .o_data  (buf_data)
    );

    // Slot usage: x0 writes do not occupy the port; a younger pipe write to the
    // buffered rd makes the buffered result dead.
    assign pipe_wr = i_wb_en && (i_wb_rd != REG_X0);
    assign busy    = (state_q != IDLE);
    assign collide = busy && pipe_wr && (i_wb_rd == buf_rd);
    assign drain   = busy && buf_valid && !pipe_wr;

    // State, counter and sticky error registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    // Next state, starvation count, buffer control and error detection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_mdu_valid && (i_mdu_rd != REG_X0)) begin
                    buf_load = 1'b1;
                    cnt_d    = '0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (collide || drain) begin
                    buf_clear = 1'b1;
                    state_d   = IDLE;
                end else begin
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + WB_CNT_W'(1);
                    end
                    if (cnt_q == CNT_LIMIT) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                if (collide || drain) begin
                    buf_clear = 1'b1;
                    state_d   = IDLE;
                end else if (pipe_wr) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        stall_d = (state_d == FORCE);
    end

    // Handshake, hazard outputs and write-port mux; all forced low during reset.
    always_comb begin
        o_mdu_ready  = 1'b0;
        o_buf_busy   = 1'b0;
        o_buf_rd     = REG_X0;
        o_reg_w_en   = 1'b0;
        o_reg_w      = REG_X0;
        o_reg_w_reg  = '0;
        o_pipe_stall = stall_q && !i_rst;
        o_err        = err_q && !i_rst;
        if (!i_rst) begin
            o_mdu_ready = (state_q == IDLE);
            o_buf_busy  = busy;
            o_buf_rd    = busy ? buf_rd : REG_X0;
            if (pipe_wr) begin
                o_reg_w_en  = 1'b1;
                o_reg_w     = i_wb_rd;
                o_reg_w_reg = i_wb_data;
            end else if (drain) begin
                o_reg_w_en  = 1'b1;
                o_reg_w     = buf_rd;
                o_reg_w_reg = buf_data;
            end
        end
    end

endmodule

// File: tb/tb_nnrv_wb_arb.sv
// Scoreboard bench for nnrv_wb_arb: stimulus pushes expected writes tagged with
// their cycle; a negedge monitor pops and compares every register-file write.
module tb_nnrv_wb_arb;

    localparam int unsigned XLEN = 64;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [63:0]     wb_data;
    logic            mdu_valid;
    logic [4:0]      mdu_rd;
    logic [63:0]     mdu_data;
    logic            mdu_ready;
    logic            pipe_stall;
    logic            buf_busy;
    logic [4:0]      buf_rd;
    logic            err;
    logic            w_en;
    logic [4:0]      w_rd;
    logic [63:0]     w_data;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    nnrv_wb_arb #(
        .XLEN       (XLEN),
        .STARVE_MAX (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wb_en      (wb_en),
        .i_wb_rd      (wb_rd),
        .i_wb_data    (wb_data),
        .i_mdu_valid  (mdu_valid),
        .i_mdu_rd     (mdu_rd),
        .i_mdu_data   (mdu_data),
        .o_mdu_ready  (mdu_ready),
        .o_pipe_stall (pipe_stall),
        .o_buf_busy   (buf_busy),
        .o_buf_rd     (buf_rd),
        .o_err        (err),
        .o_reg_w_en   (w_en),
        .o_reg_w      (w_rd),
        .o_reg_w_reg  (w_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write must match the expectation tagged for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            total++;
            if (!w_en || w_rd !== e.rd || w_data !== e.data) begin
                bad++;
                $display("FAIL write cyc=%0d: got en=%0b rd=%0d data=%h, want rd=%0d data=%h",
                         cyc, w_en, w_rd, w_data, e.rd, e.data);
            end
        end else if (w_en) begin
            total++;
            bad++;
            $display("FAIL unexpected write cyc=%0d: got rd=%0d data=%h, want no write",
                     cyc, w_rd, w_data);
        end
    end

    task automatic push_exp(input logic [4:0] rd, input logic [63:0] data);
        exp_t e;
        e.cyc  = cyc;
        e.rd   = rd;
        e.data = data;
        q.push_back(e);
    endtask

    // Apply one cycle of inputs just after the edge; pipe writes are expected at once.
    task automatic drive(input logic r, input logic we, input logic [4:0] wrd,
                         input logic [63:0] wd, input logic mv, input logic [4:0] mrd,
                         input logic [63:0] md);
        @(posedge clk);
        #1;
        rst       = r;
        wb_en     = we;
        wb_rd     = wrd;
        wb_data   = wd;
        mdu_valid = mv;
        mdu_rd    = mrd;
        mdu_data  = md;
        if (!r && we && wrd != 5'd0) push_exp(wrd, wd);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, want);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " w_en"}, 64'(w_en), 64'h0);
        chk({nm, " w_rd"}, 64'(w_rd), 64'h0);
        chk({nm, " w_data"}, w_data, 64'h0);
        chk({nm, " ready"}, 64'(mdu_ready), 64'h0);
        chk({nm, " busy"}, 64'(buf_busy), 64'h0);
        chk({nm, " buf_rd"}, 64'(buf_rd), 64'h0);
        chk({nm, " stall"}, 64'(pipe_stall), 64'h0);
        chk({nm, " err"}, 64'(err), 64'h0);
    endtask

    initial begin
        rst = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 64'h0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 64'h0;

        // Reset with a pipe write present: everything must stay low.
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        drive(1'b1, 1'b1, 5'd3, 64'h55, 1'b0, 5'd0, 64'h0);
        chk_all_zero("reset");

        // Reset mid-operation: accepted rd=7 is dropped, never written.
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h11);
        chk("acc7 ready", 64'(mdu_ready), 64'h1);
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        chk_all_zero("midreset");
        idle();
        chk("postreset busy", 64'(buf_busy), 64'h0);
        chk("postreset ready", 64'(mdu_ready), 64'h1);
        idle();

        // Idle port: MDU rd=5 written one cycle after accept.
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'hAB);
        chk("acc5 ready", 64'(mdu_ready), 64'h1);
        idle();
        push_exp(5'd5, 64'hAB);
        chk("drain5 ready", 64'(mdu_ready), 64'h0);
        chk("drain5 busy", 64'(buf_busy), 64'h1);
        chk("drain5 buf_rd", 64'(buf_rd), 64'd5);
        idle();
        chk("after5 ready", 64'(mdu_ready), 64'h1);
        chk("after5 busy", 64'(buf_busy), 64'h0);
        chk("after5 buf_rd", 64'(buf_rd), 64'd0);

        // Pipe priority, then drain into an x0 slot.
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd6, 64'h66);
        drive(1'b0, 1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'h0);
        chk("prio busy", 64'(buf_busy), 64'h1);
        chk("prio buf_rd", 64'(buf_rd), 64'd6);
        drive(1'b0, 1'b1, 5'd0, 64'h99, 1'b0, 5'd0, 64'h0);
        push_exp(5'd6, 64'h66);
        idle();
        chk("x0slot busy", 64'(buf_busy), 64'h0);

        // MDU result to x0: accepted, never written, buffer stays empty.
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'h77);
        chk("mdu_x0 ready", 64'(mdu_ready), 64'h1);
        idle();
        chk("mdu_x0 busy", 64'(buf_busy), 64'h0);
        chk("mdu_x0 ready2", 64'(mdu_ready), 64'h1);

        // Starvation: four blocked cycles, then FORCE drains on the idle slot.
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd8, 64'h88);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 5'(i), 64'(32'h100 + i), 1'b0, 5'd0, 64'h0);
            chk($sformatf("starve%0d stall", i), 64'(pipe_stall), 64'h0);
        end
        idle();
        push_exp(5'd8, 64'h88);
        chk("force stall", 64'(pipe_stall), 64'h1);
        chk("force busy", 64'(buf_busy), 64'h1);
        idle();
        chk("unforce stall", 64'(pipe_stall), 64'h0);
        chk("unforce busy", 64'(buf_busy), 64'h0);
        chk("unforce err", 64'(err), 64'h0);

        // Same-rd collision: pipe value wins, buffer discarded.
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 64'h99);
        drive(1'b0, 1'b1, 5'd9, 64'h22, 1'b0, 5'd0, 64'h0);
        chk("collide busy", 64'(buf_busy), 64'h1);
        idle();
        chk("collide idle busy", 64'(buf_busy), 64'h0);
        chk("collide idle ready", 64'(mdu_ready), 64'h1);
        idle();

        // Protocol violation: pipe keeps writing in FORCE, error sticks.
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd10, 64'hAA);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 5'd2, 64'(32'h200 + i), 1'b0, 5'd0, 64'h0);
        end
        drive(1'b0, 1'b1, 5'd2, 64'h204, 1'b0, 5'd0, 64'h0);
        chk("viol1 stall", 64'(pipe_stall), 64'h1);
        chk("viol1 err", 64'(err), 64'h0);
        drive(1'b0, 1'b1, 5'd2, 64'h205, 1'b0, 5'd0, 64'h0);
        chk("viol2 stall", 64'(pipe_stall), 64'h1);
        chk("viol2 err", 64'(err), 64'h1);
        idle();
        push_exp(5'd10, 64'hAA);
        chk("viol drain stall", 64'(pipe_stall), 64'h1);
        chk("viol drain err", 64'(err), 64'h1);
        idle();
        chk("viol after stall", 64'(pipe_stall), 64'h0);
        chk("viol after err", 64'(err), 64'h1);
        chk("viol after busy", 64'(buf_busy), 64'h0);

        // Only reset clears the sticky error.
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        chk_all_zero("reset2");
        idle();
        chk("reset2 err", 64'(err), 64'h0);
        idle();
        idle();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d pending writes want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nnrv_wb_arb.md
Name: nnrv_wb_arb

Overview:
- Arbiter for the single register-file write port.
- Requester A is the in-order pipeline writeback (mem stage result). It has priority and a zero-latency pass-through.
- Requester B is a multicycle unit (mul/div result) with a valid/ready handshake. Its result is held in a one-entry buffer and written in the first free port slot.
- A starvation counter stalls the pipeline so that requester B always drains. The block sits between the mem stage / MDU and the register file.

Parameters:
- XLEN, 64, register/data width.
- STARVE_MAX, 4, consecutive blocked cycles (range 1..15) before the pipeline stall is requested.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_wb_en  input  1  pipeline write request.
- i_wb_rd  input  5  pipeline destination register.
- i_wb_data  input  XLEN  pipeline write data.
- i_mdu_valid  input  1  MDU result valid.
- i_mdu_rd  input  5  MDU destination register.
- i_mdu_data  input  XLEN  MDU result data.
- o_mdu_ready  output  1  buffer can accept an MDU result.
- o_pipe_stall  output  1  registered; pipeline must freeze and present i_wb_en=0.
- o_buf_busy  output  1  buffer holds a pending write (for the hazard unit).
- o_buf_rd  output  5  pending destination register; 0 when not busy.
- o_err  output  1  sticky protocol-violation flag.
- o_reg_w_en  output  1  register file write enable.
- o_reg_w  output  5  register file write address.
- o_reg_w_reg  output  XLEN  register file write data.

Behaviour:
- Reset: one clock, synchronous, active-high. The whole block is reset by i_rst on the i_clk edge.
  - While i_rst is high: state=IDLE, buffer cleared, cnt=0, o_err=0, o_pipe_stall=0.
  - While i_rst is high: o_reg_w_en=0, o_reg_w=0, o_reg_w_reg=0, o_mdu_ready=0, o_buf_busy=0, o_buf_rd=0.
  - Reset mid-operation drops any buffered result without writing it.
- Port slot free: true when i_wb_en==0, or i_wb_rd==0 (writes to x0 are suppressed).
- Output mux (combinational):
  - If i_wb_en and i_wb_rd!=0: drive pipe rd/data with o_reg_w_en=1. Latency is 0, as for a direct writeback.
  - Else if the buffer is draining this cycle: drive buf rd/data with o_reg_w_en=1.
  - Else: o_reg_w_en=0, o_reg_w=0, o_reg_w_reg=0.
- State machine (states IDLE, HOLD, FORCE):
  - IDLE:
    - o_mdu_ready=1.
    - On i_mdu_valid with i_mdu_rd!=0: latch rd/data, cnt=0, go to HOLD.
    - On i_mdu_valid with i_mdu_rd==0: accept and discard, stay IDLE.
  - HOLD:
    - o_mdu_ready=0.
    - If the pipe writes rd==buf_rd (nonzero): discard the buffer, because the pipe result is younger. Go to IDLE.
    - Else if the slot is free: drain the buffer, go to IDLE.
    - Else: cnt++. When cnt reaches STARVE_MAX-1 (blocked for STARVE_MAX cycles), go to FORCE.
  - FORCE:
    - o_pipe_stall=1 (the registered output is high for exactly the cycles spent in FORCE).
    - Same-rd discard and free-slot drain rules as HOLD; both go to IDLE, and o_pipe_stall drops the next cycle.
    - If a non-x0 pipe write arrives anyway: the pipe still wins, o_err is set (sticky until reset), stay FORCE.
- Write latency: MDU accept to register write is at least 1 cycle, and at most STARVE_MAX+1 cycles with a compliant pipeline.
- o_buf_busy = (state != IDLE); o_buf_rd = buf_rd when busy, else 0.
- Back-to-back MDU results:
  - ready is low while HOLD/FORCE, so the sustained rate is one result per 2 cycles.
  - Ready and buffer-drain never overlap in the same cycle.
- cnt saturates; it never wraps.

Decomposition:
- Shared package nnrv_pkg:
  - wb_arb_state_t enum (IDLE, HOLD, FORCE).
  - REG_ADDR_W=5.
  - REG_X0=5'd0.
- Sub-module nnrv_wb_buf: one-entry valid/rd/data holding register with load/clear.
- FSM, counter and output mux stay in nnrv_wb_arb.

Test Plan:
- Reset mid-operation: accept MDU rd=7 data=0x11, assert i_rst next cycle -> buffer dropped, no write of x7 ever occurs, all outputs 0 during reset.
- Idle port: pipe idle, MDU valid rd=5 data=0xAB accepted at cycle t -> o_reg_w_en=1, rd=5, data=0xAB at t+1; o_mdu_ready low at t+1, high at t+2.
- Pipe priority and x0 rules:
  - Pipe writes rd=3 while MDU rd=6 is buffered -> rd=3 written, buffer held, o_buf_rd=6.
  - Pipe rd=0 slot -> buffer drains in that cycle.
  - MDU rd=0 -> accepted, never written.
- Starvation, STARVE_MAX=4: pipe writes rd=1..4 continuously after an MDU accept -> o_pipe_stall=1 after 4 blocked cycles; the pipe then idles -> MDU write occurs, stall drops the next cycle, o_err=0.
- Same-rd collision: MDU rd=9 buffered, pipe writes rd=9 data=0x22 -> register written with 0x22 only, buffer discarded, state IDLE.
- Protocol violation: in FORCE the pipe keeps writing rd=2 -> pipe writes pass through, o_err=1 sticky, the buffer drains on the first idle slot.
